// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared constants for the spiking-network layers
// Holds per-layer default firing thresholds, the default leak shift and the
// default packed batch-norm byte {addend[7:4], factor[3:0]} used by the layers.
package snn_pkg;

    localparam int BN_PARAM_BITS = 8;

    localparam int DEFAULT_THRESHOLD_L1 = 3;
    localparam int DEFAULT_THRESHOLD_L2 = 7;
    localparam int DEFAULT_THRESHOLD_L3 = 9;

    localparam int DEFAULT_SHIFT = 4;

    // factor = 2 (x1 in half-units), addend = 0
    localparam logic [BN_PARAM_BITS-1:0] DEFAULT_BN_BYTE = 8'h02;

endpackage

// File: rtl/snn_weighted_popcount.sv
// rtl/snn_weighted_popcount.sv - combinational signed +1/-1 weighted spike sum
// Ports:
//   inputs  [SYNAPSES]  spike inputs
//   weights [SYNAPSES]  1 = +1, 0 = -1
//   sum     [SUM_BITS]  signed sum, range +/-SYNAPSES
module snn_weighted_popcount #(
    parameter int SYNAPSES = 16,
    parameter int SUM_BITS = $clog2(SYNAPSES) + 2
) (
    input  logic [SYNAPSES-1:0]        inputs,
    input  logic [SYNAPSES-1:0]        weights,
    output logic signed [SUM_BITS-1:0] sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < SYNAPSES; i++) begin
            if (inputs[i]) begin
                if (weights[i]) begin
                    sum = sum + SUM_BITS'(1);
                end else begin
                    sum = sum - SUM_BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/snn_lif_neuron.sv
// rtl/snn_lif_neuron.sv - leaky integrate-and-fire neuron with binary weights and batch norm
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   enable              perform one integration step this cycle
//   inputs, weights     spike inputs and per-synapse +1/-1 weights
//   batchnorm_factor    unsigned scale in half-units (2 = x1)
//   batchnorm_addend    signed addend
//   shift               leak shift amount, 0 = no leak
//   threshold           unsigned firing threshold
//   is_spike            registered spike flag
module snn_lif_neuron
    import snn_pkg::*;
#(
    parameter int SYNAPSES              = 16,
    parameter int THRESHOLD_BITS        = 5,
    parameter int BATCHNORM_ADDEND_BITS = 4,
    parameter int MEMBRANE_BITS         = $clog2(SYNAPSES) + 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [SYNAPSES-1:0]              inputs,
    input  logic [SYNAPSES-1:0]              weights,
    input  logic [3:0]                       batchnorm_factor,
    input  logic [BATCHNORM_ADDEND_BITS-1:0] batchnorm_addend,
    input  logic [2:0]                       shift,
    input  logic [THRESHOLD_BITS-1:0]        threshold,
    output logic                             is_spike
);

    localparam int SUM_BITS = $clog2(SYNAPSES) + 2;
    // Two guard bits so u - L + B can never wrap before saturation.
    localparam int WIDE = MEMBRANE_BITS + 2;

    localparam logic signed [WIDE-1:0] WIDE_MAX = WIDE'((1 <<< (MEMBRANE_BITS - 1)) - 1);
    localparam logic signed [WIDE-1:0] WIDE_MIN = -WIDE'(1 <<< (MEMBRANE_BITS - 1));
    localparam logic signed [MEMBRANE_BITS-1:0] MEM_MAX = {1'b0, {(MEMBRANE_BITS-1){1'b1}}};
    localparam logic signed [MEMBRANE_BITS-1:0] MEM_MIN = {1'b1, {(MEMBRANE_BITS-1){1'b0}}};

    logic signed [MEMBRANE_BITS-1:0] membrane;
    logic signed [SUM_BITS-1:0]      weighted_sum;

    logic signed [WIDE-1:0] sum_wide;
    logic signed [WIDE-1:0] factor_wide;
    logic signed [WIDE-1:0] addend_wide;
    logic signed [WIDE-1:0] membrane_wide;
    logic signed [WIDE-1:0] product;
    logic signed [WIDE-1:0] batchnorm;
    logic signed [WIDE-1:0] leak;
    logic signed [WIDE-1:0] candidate;

    logic signed [MEMBRANE_BITS-1:0] candidate_sat;
    logic signed [MEMBRANE_BITS-1:0] threshold_ext;
    logic                            fire;
    logic signed [MEMBRANE_BITS-1:0] next_membrane;

    snn_weighted_popcount #(
        .SYNAPSES (SYNAPSES),
        .SUM_BITS (SUM_BITS)
    ) u_popcount (
        .inputs  (inputs),
        .weights (weights),
        .sum     (weighted_sum)
    );

    always_comb begin
        sum_wide      = {{(WIDE-SUM_BITS){weighted_sum[SUM_BITS-1]}}, weighted_sum};
        factor_wide   = {{(WIDE-4){1'b0}}, batchnorm_factor};
        addend_wide   = {{(WIDE-BATCHNORM_ADDEND_BITS){batchnorm_addend[BATCHNORM_ADDEND_BITS-1]}},
                         batchnorm_addend};
        membrane_wide = {{(WIDE-MEMBRANE_BITS){membrane[MEMBRANE_BITS-1]}}, membrane};

        // Factor is in half-units; arithmetic shift floors toward -inf.
        product   = sum_wide * factor_wide;
        batchnorm = (product >>> 1) + addend_wide;

        leak      = (shift == 3'd0) ? '0 : (membrane_wide >>> shift);
        candidate = membrane_wide - leak + batchnorm;

        if (candidate > WIDE_MAX) begin
            candidate_sat = MEM_MAX;
        end else if (candidate < WIDE_MIN) begin
            candidate_sat = MEM_MIN;
        end else begin
            candidate_sat = candidate[MEMBRANE_BITS-1:0];
        end

        threshold_ext = {{(MEMBRANE_BITS-THRESHOLD_BITS){1'b0}}, threshold};
        fire          = (candidate_sat >= threshold_ext);
        // Reset by subtraction; cannot underflow since candidate >= threshold >= 0.
        next_membrane = fire ? (candidate_sat - threshold_ext) : candidate_sat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            membrane <= '0;
            is_spike <= 1'b0;
        end else if (enable) begin
            membrane <= next_membrane;
            is_spike <= fire;
        end else begin
            is_spike <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snn_lif_neuron.sv
// tb/tb_snn_lif_neuron.sv - directed self-checking bench for snn_lif_neuron
module tb_snn_lif_neuron;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] inputs;
    logic [15:0] weights;
    logic [3:0]  batchnorm_factor;
    logic [3:0]  batchnorm_addend;
    logic [2:0]  shift;
    logic [4:0]  threshold;
    logic        is_spike;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snn_lif_neuron dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .inputs           (inputs),
        .weights          (weights),
        .batchnorm_factor (batchnorm_factor),
        .batchnorm_addend (batchnorm_addend),
        .shift            (shift),
        .threshold        (threshold),
        .is_spike         (is_spike)
    );

    task automatic step_check(input string tag, input int exp_u, input logic exp_s);
        int obs_u;
        @(posedge clk);
        #1;
        obs_u = int'(dut.membrane);
        checks++;
        assert (obs_u === exp_u) else begin
            failures++;
            $error("FAIL %s membrane observed=%0d expected=%0d", tag, obs_u, exp_u);
        end
        checks++;
        assert (is_spike === exp_s) else begin
            failures++;
            $error("FAIL %s is_spike observed=%b expected=%b", tag, is_spike, exp_s);
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step_check(tag, 0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        enable           = 1'b0;
        inputs           = '0;
        weights          = '0;
        batchnorm_factor = 4'd2;
        batchnorm_addend = 4'd0;
        shift            = 3'd0;
        threshold        = 5'd9;

        do_reset("reset_initial");

        // S = +16, B = 16, threshold 9: u = 7, 14, 21 with a spike each step
        inputs  = 16'hFFFF;
        weights = 16'hFFFF;
        enable  = 1'b1;
        step_check("pos_1", 7, 1'b1);
        step_check("pos_2", 14, 1'b1);
        step_check("pos_3", 21, 1'b1);

        // reset wins over enable
        reset = 1'b1;
        step_check("reset_with_enable", 0, 1'b0);
        reset = 1'b0;

        // enable gap mid-accumulation
        step_check("gap_pre_1", 7, 1'b1);
        step_check("gap_pre_2", 14, 1'b1);
        enable = 1'b0;
        step_check("gap_hold_1", 14, 1'b0);
        step_check("gap_hold_2", 14, 1'b0);
        step_check("gap_hold_3", 14, 1'b0);
        enable = 1'b1;
        step_check("gap_resume_1", 21, 1'b1);
        step_check("gap_resume_2", 28, 1'b1);

        // S = -16: u falls by 16 per step and saturates at -256
        do_reset("reset_neg");
        weights = 16'h0000;
        for (int k = 1; k <= 16; k++) begin
            step_check($sformatf("neg_%0d", k), -16 * k, 1'b0);
        end
        step_check("neg_saturated", -256, 1'b0);

        // S = 2, shift 1: u = 2, 3, 4, 4, 4
        do_reset("reset_leak");
        inputs  = 16'h0003;
        weights = 16'hFFFF;
        shift   = 3'd1;
        step_check("leak_1", 2, 1'b0);
        step_check("leak_2", 3, 1'b0);
        step_check("leak_3", 4, 1'b0);
        step_check("leak_4", 4, 1'b0);
        step_check("leak_5", 4, 1'b0);

        // S = -3, factor 1: (-3 >>> 1) = -2 (floor)
        do_reset("reset_floor");
        inputs           = 16'h0007;
        weights          = 16'h0000;
        shift            = 3'd0;
        batchnorm_factor = 4'd1;
        step_check("floor_1", -2, 1'b0);
        step_check("floor_2", -4, 1'b0);

        // addend +3 only, threshold 3: fire every step, u stays 0
        do_reset("reset_addend");
        inputs           = 16'h0000;
        batchnorm_factor = 4'd2;
        batchnorm_addend = 4'b0011;
        threshold        = 5'd3;
        step_check("addend_1", 0, 1'b1);
        step_check("addend_2", 0, 1'b1);
        step_check("addend_3", 0, 1'b1);

        // factor 1, S = 3, addend -2: B = 1 - 2 = -1 per step
        inputs           = 16'h0007;
        weights          = 16'hFFFF;
        batchnorm_factor = 4'd1;
        batchnorm_addend = 4'b1110;
        step_check("decay_1", -1, 1'b0);
        step_check("decay_2", -2, 1'b0);
        step_check("decay_3", -3, 1'b0);

        // threshold 0 with v = 0 still fires
        do_reset("reset_thr0");
        inputs           = 16'h0000;
        batchnorm_factor = 4'd2;
        batchnorm_addend = 4'd0;
        threshold        = 5'd0;
        step_check("thr0_1", 0, 1'b1);
        step_check("thr0_2", 0, 1'b1);

        // factor 0: only the addend (+5) contributes
        do_reset("reset_factor0");
        inputs           = 16'hFFFF;
        weights          = 16'hFFFF;
        batchnorm_factor = 4'd0;
        batchnorm_addend = 4'b0101;
        threshold        = 5'd9;
        step_check("factor0_1", 5, 1'b0);
        step_check("factor0_2", 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
